// File: rtl/holiday_pkg.sv
// Shared types and constants for the holiday-lights front end.
package holiday_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int CLK_HZ             = 100_000_000;
    // 10 ms of stable level at the system clock rate
    localparam int DEB_CYCLES_DEFAULT = CLK_HZ / 100;
    localparam int SW_W               = 3;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous board inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture; the first stage may go metastable, the second is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_sw_conditioner.sv
// Button/switch conditioner feeding the LED stage: synchronises both inputs,
// debounces the button, and emits a press pulse with a switch snapshot.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | button released and accepted as released
// PRESS_WAIT   | button seen high, counting stable-high cycles
// PRESSED      | press accepted (pulse issued), waiting for button low
// RELEASE_WAIT | button seen low, counting stable-low cycles before re-arming
module button_sw_conditioner #(
    parameter int DEB_CYCLES = holiday_pkg::DEB_CYCLES_DEFAULT,
    parameter int SW_W       = holiday_pkg::SW_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            button_in,
    input  logic [SW_W-1:0] switch_in,
    output logic            btn_pulse,
    output logic [SW_W-1:0] sw_hold,
    output logic            btn_level
);

    import holiday_pkg::state_t;
    import holiday_pkg::IDLE;
    import holiday_pkg::PRESS_WAIT;
    import holiday_pkg::PRESSED;
    import holiday_pkg::RELEASE_WAIT;

    localparam int                CNT_W    = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic            btn_s;
    logic [SW_W-1:0] sw_s;
    state_t          state;
    logic [CNT_W-1:0] cnt;

    sync_2ff #(.W(1)) u_sync_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (button_in),
        .q     (btn_s)
    );

    sync_2ff #(.W(SW_W)) u_sync_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (switch_in),
        .q     (sw_s)
    );

    // Debounce FSM with registered pulse, snapshot and level outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_pulse <= 1'b0;
            sw_hold   <= '0;
            btn_level <= 1'b0;
        end else begin
            btn_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        btn_pulse <= 1'b1;
                        sw_hold   <= sw_s;
                        btn_level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A return to high here is release bounce: back to PRESSED without a pulse.
                    if (btn_s) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_sw_conditioner.sv
// Self-checking bench for button_sw_conditioner with a short debounce window.
module tb_button_sw_conditioner;

    localparam int DEB  = 4;
    localparam int SW_W = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            button_in = 1'b0;
    logic [SW_W-1:0] switch_in = '0;
    logic            btn_pulse;
    logic [SW_W-1:0] sw_hold;
    logic            btn_level;

    button_sw_conditioner #(.DEB_CYCLES(DEB), .SW_W(SW_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .button_in (button_in),
        .switch_in (switch_in),
        .btn_pulse (btn_pulse),
        .sw_hold   (sw_hold),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: inputs reach the debouncer two edges late; a level change is
    // accepted once the delayed input has disagreed with the accepted level for DEB+1
    // consecutive edges.
    bit              q_b[$];
    logic [SW_W-1:0] q_sw[$];
    int              m_run;
    bit              m_lvl;
    bit              m_pulse;
    logic [SW_W-1:0] m_hold;

    typedef struct {
        bit              b;
        logic [SW_W-1:0] sw;
        bit              ep;
        logic [SW_W-1:0] eh;
        bit              el;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q_b.delete();
        q_sw.delete();
        q_b.push_back(1'b0);
        q_b.push_back(1'b0);
        q_sw.push_back('0);
        q_sw.push_back('0);
        m_run   = 0;
        m_lvl   = 1'b0;
        m_pulse = 1'b0;
        m_hold  = '0;
    endtask

    task automatic model_step(input bit b, input logic [SW_W-1:0] sw);
        bit              s;
        logic [SW_W-1:0] ss;
        s  = q_b.pop_front();
        ss = q_sw.pop_front();
        q_b.push_back(b);
        q_sw.push_back(sw);
        m_pulse = 1'b0;
        if (s != m_lvl) m_run++;
        else            m_run = 0;
        if (m_run == DEB + 1) begin
            m_run = 0;
            m_lvl = s;
            if (s) begin
                m_pulse = 1'b1;
                m_hold  = ss;
            end
        end
    endtask

    task automatic cycle(input bit b, input logic [SW_W-1:0] sw);
        button_in = b;
        switch_in = sw;
        @(posedge clk);
        model_step(b, sw);
        #1;
        chk("model_pulse", btn_pulse, m_pulse);
        chk("model_hold", sw_hold, m_hold);
        chk("model_level", btn_level, m_lvl);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_pulse"}, btn_pulse, 0);
        chk({name, "_hold"}, sw_hold, 0);
        chk({name, "_level"}, btn_level, 0);
    endtask

    task automatic reset_for(input int n);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero("rst_async");
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        int pedge;
        int bounce_pulses;
        int remaining;
        bit rb;

        for (int i = 0; i < 20; i++) begin
            tbl[i].b  = 1'b1;
            tbl[i].sw = 3'b101;
            tbl[i].ep = (i == 6);
            tbl[i].eh = (i >= 6) ? 3'b101 : 3'b000;
            tbl[i].el = (i >= 6);
        end

        // Reset with the button held and all switches on
        button_in = 1'b1;
        switch_in = 3'b111;
        reset_for(3);
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 3'b111);
            check_zero("post_rst");
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 3'b111);

        // Clean press from a fresh reset, table-driven
        button_in = 1'b0;
        switch_in = '0;
        reset_for(2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'b000);
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].b, tbl[i].sw);
            chk("tbl_pulse", btn_pulse, tbl[i].ep);
            chk("tbl_hold", sw_hold, tbl[i].eh);
            chk("tbl_level", btn_level, tbl[i].el);
        end
        for (int i = 0; i < 10; i++) cycle(1'b0, 3'b101);
        chk("release_level", btn_level, 0);

        // Press bounce: 1,0,1,1,0 then steady high
        bounce_pulses = 0;
        cycle(1'b1, 3'b010); bounce_pulses += btn_pulse;
        cycle(1'b0, 3'b010); bounce_pulses += btn_pulse;
        cycle(1'b1, 3'b010); bounce_pulses += btn_pulse;
        cycle(1'b1, 3'b010); bounce_pulses += btn_pulse;
        cycle(1'b0, 3'b010); bounce_pulses += btn_pulse;
        pulses = 0;
        pedge  = -1;
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 3'b010);
            if (btn_pulse) begin
                pulses++;
                pedge = i;
            end
        end
        chk("bounce_nopulse", bounce_pulses, 0);
        chk("bounce_count", pulses, 1);
        chk("bounce_edge", pedge, 7);
        chk("bounce_hold", sw_hold, 3'b010);

        // Release bounce while pressed
        pulses = 0;
        cycle(1'b0, 3'b010);
        chk("relb_level", btn_level, 1);
        cycle(1'b0, 3'b010);
        chk("relb_level", btn_level, 1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 3'b010);
            chk("relb_level", btn_level, 1);
            pulses += btn_pulse;
        end
        chk("relb_nopulse", pulses, 0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 3'b011);
        chk("relb_released", btn_level, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 3'b011);
            pulses += btn_pulse;
        end
        chk("second_press", pulses, 1);
        chk("second_hold", sw_hold, 3'b011);
        for (int i = 0; i < 10; i++) cycle(1'b0, 3'b011);

        // Switch motion while idle is invisible
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'b001);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 3'b110);
            chk("iso_hold", sw_hold, 3'b011);
        end
        for (int i = 0; i < 10; i++) cycle(1'b1, 3'b110);
        chk("iso_newhold", sw_hold, 3'b110);
        for (int i = 0; i < 10; i++) cycle(1'b0, 3'b110);

        // Reset one edge before the expected pulse
        for (int i = 1; i <= 6; i++) cycle(1'b1, 3'b100);
        reset_for(2);
        button_in = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 3'b100);
            pulses += btn_pulse;
            check_zero("mid_rst");
        end
        chk("mid_rst_nopulse", pulses, 0);
        pedge = -1;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 3'b100);
            if (btn_pulse && pedge < 0) pedge = i;
        end
        chk("mid_rst_idle", pedge, 7);
        for (int i = 0; i < 10; i++) cycle(1'b0, 3'b100);

        // Randomised runs of button levels against the model
        remaining = 0;
        rb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_for(2);
            end
            if (remaining == 0) begin
                rb = 1'($urandom_range(0, 1));
                remaining = $urandom_range(1, 9);
            end
            cycle(rb, 3'($urandom_range(0, 7)));
            remaining--;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
